lfsr_checker_8bit: RTL and testbench



---
 rtl/lfsr_chk_pkg.sv | 12 +
 rtl/lfsr_popcount8.sv | 12 +
 rtl/lfsr_checker_8bit.sv | 114 +++++++++++
 tb/tb_lfsr_checker_8bit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_chk_pkg.sv
// lfsr_chk_pkg: shared types and the LFSR step function for the 8-bit LFSR checker.
package lfsr_chk_pkg;

    typedef enum logic {SEARCH, LOCKED} state_e;

    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] x);
        return {x[6:0], ^(x & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_popcount8.sv
// lfsr_popcount8: number of set bits in a byte.
module lfsr_popcount8 (
    input  logic [7:0] data_i,
    output logic [3:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < 8; i++) count_o = count_o + {3'b0, data_i[i]};
    end

endmodule

// File: rtl/lfsr_checker_8bit.sv
// lfsr_checker_8bit: self-synchronising checker for the 8-bit Fibonacci LFSR byte stream.
// Define LFSR_CHK_BITCNT_EN to count mismatching bits instead of mismatching bytes.
module lfsr_checker_8bit
    import lfsr_chk_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_valid,
    input  logic [7:0]       data_in,
    input  logic             cnt_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int XW = $clog2(LOSS_CNT + 1);
    localparam int SW = ERR_W + 4;
    localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_CNT - 1);
    localparam logic [XW-1:0]    LOSS_LAST = XW'(LOSS_CNT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_e           state_q, state_d;
    logic [7:0]       ref_q, ref_d;
    logic             ref_vld_q, ref_vld_d;
    logic [MW-1:0]    match_run_q, match_run_d;
    logic [XW-1:0]    miss_run_q, miss_run_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       exp_byte;
    logic             is_match, miss;
    logic [3:0]       inc;
    logic [SW-1:0]    sum;

    assign exp_byte = lfsr8_next(ref_q);
    assign is_match = ref_vld_q && data_in == exp_byte && data_in != 8'h00;
    assign miss     = data_valid && state_q == LOCKED && data_in != exp_byte;

`ifdef LFSR_CHK_BITCNT_EN
    logic [3:0] pop;
    lfsr_popcount8 u_pop (
        .data_i (data_in ^ exp_byte),
        .count_o(pop)
    );
    assign inc = miss ? pop : 4'd0;
`else
    assign inc = {3'b0, miss};
`endif

    // Clear applies before the increment so a coincident error still lands.
    assign sum = SW'(cnt_clr ? '0 : err_cnt_q) + SW'(inc);

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        ref_vld_d   = ref_vld_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        err_pulse_d = miss;
        err_cnt_d   = sum > SW'(ERR_MAX) ? ERR_MAX : sum[ERR_W-1:0];
        if (data_valid) begin
            if (state_q == SEARCH) begin
                ref_d       = data_in;
                ref_vld_d   = 1'b1;
                match_run_d = is_match ? match_run_q + 1'b1 : '0;
                if (is_match && match_run_q == LOCK_LAST) begin
                    state_d     = LOCKED;
                    match_run_d = '0;
                    miss_run_d  = '0;
                end
            end else begin
                // Reference free-runs while locked so one corrupt byte is one error.
                ref_d      = exp_byte;
                miss_run_d = miss ? miss_run_q + 1'b1 : '0;
                if (miss && miss_run_q == LOSS_LAST) begin
                    state_d     = SEARCH;
                    ref_d       = data_in;
                    ref_vld_d   = 1'b1;
                    match_run_d = '0;
                    miss_run_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            ref_q       <= '0;
            ref_vld_q   <= 1'b0;
            match_run_q <= '0;
            miss_run_q  <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            ref_vld_q   <= ref_vld_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = state_q == LOCKED;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker_8bit.sv
// tb_lfsr_checker_8bit: randomized and directed checks of lfsr_checker_8bit against a behavioural model.
// Two instances share stimulus: default ERR_W and ERR_W=2 for saturation.
module tb_lfsr_checker_8bit;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_valid = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        cnt_clr = 1'b0;
    logic        locked_a, err_pulse_a, locked_b, err_pulse_b;
    logic [15:0] err_cnt_a;
    logic [1:0]  err_cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int m_lock, m_ref, m_vld, m_mrun, m_xrun, m_pulse;
    int m_cnt[2];
    int m_max[2] = '{65535, 3};
    int gen;

    always #5 clk = ~clk;

    lfsr_checker_8bit #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_in(data_in), .cnt_clr(cnt_clr),
        .locked(locked_a), .err_pulse(err_pulse_a), .err_cnt(err_cnt_a)
    );

    lfsr_checker_8bit #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_in(data_in), .cnt_clr(cnt_clr),
        .locked(locked_b), .err_pulse(err_pulse_b), .err_cnt(err_cnt_b)
    );

    function automatic int nxt(input int x);
        int fb;
        fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
        return ((x << 1) & 255) | fb;
    endfunction

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_ref = 0; m_vld = 0; m_mrun = 0; m_xrun = 0; m_pulse = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    task automatic model_clock(input int v, input int d, input int clr);
        int e, inc, c;
        inc = 0;
        m_pulse = 0;
        if (v != 0) begin
            e = nxt(m_ref);
            if (m_lock == 0) begin
                if (m_vld != 0 && d == e && d != 0) m_mrun++;
                else m_mrun = 0;
                m_ref = d;
                m_vld = 1;
                if (m_mrun == LOCK_CNT) begin
                    m_lock = 1;
                    m_xrun = 0;
                    m_mrun = 0;
                end
            end else begin
                m_ref = e;
                if (d != e) begin
                    m_pulse = 1;
`ifdef LFSR_CHK_BITCNT_EN
                    inc = $countones(d ^ e);
`else
                    inc = 1;
`endif
                    m_xrun++;
                    if (m_xrun == LOSS_CNT) begin
                        m_lock = 0;
                        m_ref = d;
                        m_vld = 1;
                        m_mrun = 0;
                        m_xrun = 0;
                    end
                end else begin
                    m_xrun = 0;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            c = (clr != 0) ? 0 : m_cnt[k];
            c += inc;
            m_cnt[k] = (c > m_max[k]) ? m_max[k] : c;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".locked_a"}, int'(locked_a), m_lock);
        check({tag, ".pulse_a"}, int'(err_pulse_a), m_pulse);
        check({tag, ".cnt_a"}, int'(err_cnt_a), m_cnt[0]);
        check({tag, ".locked_b"}, int'(locked_b), m_lock);
        check({tag, ".pulse_b"}, int'(err_pulse_b), m_pulse);
        check({tag, ".cnt_b"}, int'(err_cnt_b), m_cnt[1]);
    endtask

    // Called 1 time unit after a rising edge; drives one cycle and checks its result.
    task automatic step(input string tag, input int v, input int d, input int clr);
        data_valid = v[0];
        data_in    = d[7:0];
        cnt_clr    = clr[0];
        @(posedge clk);
        model_clock(v, d, clr);
        #1;
        check_all(tag);
    endtask

    task automatic send(input string tag, input int d);
        step(tag, 1, d, 0);
    endtask

    task automatic good(input string tag);
        gen = nxt(gen);
        send(tag, gen);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, ".async_locked"}, int'(locked_a), 0);
        check({tag, ".async_cnt"}, int'(err_cnt_a), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int bytes[5] = '{8'hAA, 8'h55, 8'hAB, 8'h57, 8'hAF};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst.locked", int'(locked_a), 0);
        check("rst.pulse", int'(err_pulse_a), 0);
        check("rst.cnt", int'(err_cnt_a), 0);
        rst_n = 1'b1;

        // lock on AA..AF
        foreach (bytes[i]) send("lock", bytes[i]);
        check("lock_after_af", int'(locked_a), 1);
        check("lock_cnt0", int'(err_cnt_a), 0);

        // single corrupted byte: 5F sent as FF
        gen = 8'hAF;
        gen = nxt(gen);
        send("corrupt", 8'hFF);
        check("corrupt_pulse", int'(err_pulse_a), 1);
`ifdef LFSR_CHK_BITCNT_EN
        check("corrupt_cnt", int'(err_cnt_a), 2);
`else
        check("corrupt_cnt", int'(err_cnt_a), 1);
`endif
        good("after_corrupt");
        check("after_corrupt_pulse", int'(err_pulse_a), 0);
        repeat (3) good("run");
        check("still_locked", int'(locked_a), 1);

        // three consecutive misses drop lock; successors relock
        for (int i = 0; i < LOSS_CNT; i++) begin
            gen = nxt(gen);
            send("loss", gen ^ 8'h01);
        end
        check("lost_lock", int'(locked_a), 0);
        gen = gen ^ 8'h01;
        for (int i = 0; i < LOCK_CNT; i++) good("relock");
        check("relocked", int'(locked_a), 1);

        // saturation in the narrow instance, then clear coincident with an error
        for (int i = 0; i < 5; i++) begin
            gen = nxt(gen);
            send("sat", gen ^ 8'h80);
            good("sat_fix");
        end
        check("sat_b", int'(err_cnt_b), 3);
        gen = nxt(gen);
        step("clr_err", 1, gen ^ 8'h80, 1);
`ifndef LFSR_CHK_BITCNT_EN
        check("clr_err_b", int'(err_cnt_b), 1);
`endif
        step("clr_only", 0, 0, 1);
        check("clr_only_a", int'(err_cnt_a), 0);

        // async reset while locked, then all-zero stream never locks
        async_reset("mid");
        for (int i = 0; i < 5; i++) send("zeros", 0);
        check("zeros_unlocked", int'(locked_a), 0);

        // locking with gaps in data_valid
        async_reset("gap");
        foreach (bytes[i]) begin
            send("gap_lock", bytes[i]);
            step("gap_idle", 0, $urandom_range(0, 255), 0);
        end
        check("gap_locked", int'(locked_a), 1);

        // randomized traffic
        gen = 8'hAF;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                async_reset("rnd_rst");
            end else if (r < 10) begin
                gen = $urandom_range(1, 255);
                send("rnd_reseed", gen);
            end else if (r < 200) begin
                step("rnd_idle", 0, $urandom_range(0, 255), ($urandom_range(0, 49) == 0) ? 1 : 0);
            end else begin
                gen = nxt(gen);
                step("rnd", 1, ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : gen,
                     ($urandom_range(0, 99) == 0) ? 1 : 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
